// File: rtl/ps2_key_decoder_if.sv
// Key event bus between the PS/2 decoder and the per-core key_code consumer.
//   key_strobe   : one-cycle pulse, a key event is valid
//   key_pressed  : 1 = make, 0 = break (held until the next strobe)
//   key_extended : event was E0-prefixed (held)
//   key_code     : scan code without prefixes (held)
//   frame_err    : one-cycle pulse on parity/start/stop/timeout error
// master = decoder side (drives), slave = consumer side.
interface ps2_key_decoder_if;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       frame_err;

  modport master (
    output key_strobe, key_pressed, key_extended, key_code, frame_err
  );
  modport slave (
    input  key_strobe, key_pressed, key_extended, key_code, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard (device-to-host) receiver and set-2 prefix decoder.
//   clk_sys  : system clock, rising edge
//   res_n    : asynchronous active-low reset
//   ps2_clk  : raw PS/2 clock, asynchronous, idle high
//   ps2_data : raw PS/2 data, asynchronous, idle high
//   keys     : key event bus (master side), all outputs registered
// Parameters: FILTER_LEN     - equal synchronized samples needed to flip the
//                              filtered PS/2 clock (2..255)
//             TIMEOUT_CYCLES - idle cycles inside a frame before abandoning it
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input  logic               clk_sys,
  input  logic               res_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_key_decoder_if.master  keys
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          filt_clk;
  logic [7:0]    filt_cnt;
  logic          bit_evt, bit_data;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          brk_f, brk_f_n, ext_f, ext_f_n;
  logic          strobe_q, strobe_n, err_q, err_n;
  logic          pressed_q, pressed_n, extended_q, extended_n;
  logic [7:0]    code_q, code_n;
  logic          byte_ok;

  // Synchronizers reset high so reset release never looks like a clock fall.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Counter runs only while the synchronized level disagrees with the filtered
  // one; any agreeing sample restarts it, so short glitches are swallowed.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
      filt_clk <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  // Bit event is the cycle in which the filtered clock flips 1 -> 0.
  assign bit_evt  = filt_clk & ~clk_sync[1] & (filt_cnt == 8'(FILTER_LEN - 1));
  assign bit_data = data_sync[1];

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      brk_f      <= 1'b0;
      ext_f      <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      pressed_q  <= 1'b0;
      extended_q <= 1'b0;
      code_q     <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      par        <= par_n;
      tcnt       <= tcnt_n;
      brk_f      <= brk_f_n;
      ext_f      <= ext_f_n;
      strobe_q   <= strobe_n;
      err_q      <= err_n;
      pressed_q  <= pressed_n;
      extended_q <= extended_n;
      code_q     <= code_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_n      = par;
    tcnt_n     = tcnt;
    brk_f_n    = brk_f;
    ext_f_n    = ext_f;
    strobe_n   = 1'b0;
    err_n      = 1'b0;
    pressed_n  = pressed_q;
    extended_n = extended_q;
    code_n     = code_q;
    byte_ok    = 1'b0;

    if (bit_evt) tcnt_n = '0;
    else if (state != IDLE) tcnt_n = tcnt + TW'(1);

    case (state)
      IDLE: if (bit_evt) begin
        if (!bit_data) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end else begin
          err_n = 1'b1;
        end
      end
      DATA: if (bit_evt) begin
        shift_n   = {bit_data, shift[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (bit_evt) begin
        par_n   = bit_data;
        state_n = STOP;
      end
      STOP: if (bit_evt) begin
        state_n = IDLE;
        if (bit_data && ((^shift) ^ par)) byte_ok = 1'b1;
        else err_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // A bit event in the expiry cycle takes precedence over the timeout.
    if (!bit_evt && state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      err_n   = 1'b1;
      state_n = IDLE;
      tcnt_n  = '0;
    end

    if (byte_ok) begin
      case (shift)
        8'hE0: ext_f_n = 1'b1;
        8'hF0: brk_f_n = 1'b1;
        8'hE1: ;
        default: begin
          code_n     = shift;
          pressed_n  = ~brk_f;
          extended_n = ext_f;
          strobe_n   = 1'b1;
          brk_f_n    = 1'b0;
          ext_f_n    = 1'b0;
        end
      endcase
    end

    if (err_n) begin
      brk_f_n = 1'b0;
      ext_f_n = 1'b0;
    end
  end

  assign keys.key_strobe   = strobe_q;
  assign keys.frame_err    = err_q;
  assign keys.key_pressed  = pressed_q;
  assign keys.key_extended = extended_q;
  assign keys.key_code     = code_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus tasks push expected key
// events / frame errors into a queue, a negedge monitor pops and compares.
module tb_ps2_key_decoder;
  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 30;

  logic clk_sys  = 1'b0;
  logic res_n    = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_key_decoder_if keys();

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys  (clk_sys),
    .res_n    (res_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keys     (keys)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic       err;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   checks   = 0;
  int   failures = 0;
  logic m_brk    = 1'b0;
  logic m_ext    = 1'b0;
  bit   glitch   = 1'b0;

  initial begin
    repeat (90000) @(posedge clk_sys);
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  always @(negedge clk_sys) begin
    if (keys.key_strobe || keys.frame_err) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event strobe=%b err=%b code=%h required=none",
                 keys.key_strobe, keys.frame_err, keys.key_code);
      end else begin
        mon_e = exp_q.pop_front();
        if (keys.key_strobe && keys.frame_err) begin
          failures++;
          $display("FAIL strobe_and_err both asserted, required exclusive");
        end else if (mon_e.err) begin
          if (!keys.frame_err) begin
            failures++;
            $display("FAIL event_kind got strobe code=%h required frame_err", keys.key_code);
          end
        end else if (!keys.key_strobe || keys.key_code !== mon_e.code ||
                     keys.key_pressed !== mon_e.pressed || keys.key_extended !== mon_e.ext) begin
          failures++;
          $display("FAIL key_event got strobe=%b code=%h pressed=%b ext=%b required code=%h pressed=%b ext=%b",
                   keys.key_strobe, keys.key_code, keys.key_pressed, keys.key_extended,
                   mon_e.code, mon_e.pressed, mon_e.ext);
        end
      end
    end
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk_sys);
  endtask

  // High phase of the PS/2 clock, optionally with a short 0-glitch inside.
  task automatic hold_high(input int unsigned n);
    if (glitch && n >= 20) begin
      wait_cyc(8);
      ps2_clk = 1'b0;
      wait_cyc(FL - 3);
      ps2_clk = 1'b1;
      wait_cyc(n - 8 - (FL - 3));
    end else begin
      wait_cyc(n);
    end
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    hold_high(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int unsigned nbits);
    logic [10:0] fr;
    logic        p;
    p  = ~(^b) ^ bad_par;
    fr = {1'b1, p, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) send_bit(fr[i]);
    ps2_data = 1'b1;
  endtask

  // Reference behaviour of the prefix layer, from the byte-level rules.
  task automatic model_byte(input logic [7:0] b, input bit bad_par);
    if (bad_par) begin
      exp_q.push_back('{err: 1'b1, pressed: 1'b0, ext: 1'b0, code: 8'h00});
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE1) begin end
    else begin
      exp_q.push_back('{err: 1'b0, pressed: ~m_brk, ext: m_ext, code: b});
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0);
    model_byte(b, bad_par);
    send_frame(b, bad_par, 11);
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      wait_cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk_sys);
    checks++;
    if (keys.key_strobe !== 1'b0 || keys.frame_err !== 1'b0 || keys.key_pressed !== 1'b0 ||
        keys.key_extended !== 1'b0 || keys.key_code !== 8'h00) begin
      failures++;
      $display("FAIL %s got strobe=%b err=%b pressed=%b ext=%b code=%h required all 0",
               name, keys.key_strobe, keys.frame_err, keys.key_pressed,
               keys.key_extended, keys.key_code);
    end
  endtask

  initial begin
    logic [7:0] rb;
    int unsigned r;

    wait_cyc(3);
    check_reset_outputs("reset_state");
    res_n = 1'b1;
    wait_cyc(5);

    // Make, break, extended
    send_byte(8'h1C);
    drain("make");
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    drain("prefix");

    // Parity error clears the pending extended flag
    send_byte(8'hE0);
    send_byte(8'h1C, 1'b1);
    send_byte(8'h1C);
    drain("parity");

    // Timeout after a partial frame
    exp_q.push_back('{err: 1'b1, pressed: 1'b0, ext: 1'b0, code: 8'h00});
    m_brk = 1'b0;
    m_ext = 1'b0;
    send_frame(8'h29, 1'b0, 5);
    wait_cyc(TO + 10);
    drain("timeout");
    send_byte(8'h29);
    drain("after_timeout");

    // Glitches between and inside frames
    glitch = 1'b1;
    hold_high(HALF);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h6B);
      hold_high(HALF);
    end
    glitch = 1'b0;
    drain("glitch");

    // Random byte stream, some back-to-back, some bad parity
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = 8'hE1;
        default: rb = 8'($urandom);
      endcase
      send_byte(rb, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) wait_cyc($urandom_range(1, 40));
    end
    drain("random");

    // Reset in the middle of a frame
    send_frame(8'h76, 1'b0, 5);
    res_n = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    wait_cyc(2);
    check_reset_outputs("reset_mid_frame");
    wait_cyc(3);
    res_n = 1'b1;
    wait_cyc(5);
    send_byte(8'h76);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the serial PS/2 keyboard stream (device-to-host direction) and produces the `key_strobe` / `key_pressed` / `key_code` event interface that core tops consume for keyboard controls. It handles set-2 make, break (`F0`) and extended (`E0`) prefixes. Each completed key event is delivered as a single-cycle strobe in the `clk_sys` domain. It sits between the board PS/2 pins (or an MCU-forwarded PS/2 line) and the per-core `key_code` case decoder.

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples of synchronized `ps2_clk` needed to change its filtered level (2..255).
- `TIMEOUT_CYCLES`, default 12000: idle `clk_sys` cycles inside a frame before the frame is abandoned (2 ms at 6 MHz).
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `res_n`  in  1  asynchronous, active-low reset. This is the already-decided reset: one clock, asynchronous active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous, idle high.
- `ps2_data`  in  1  raw PS/2 data, asynchronous, idle high.
- `key_strobe`  out  1  one-cycle pulse: a key event is valid.
- `key_pressed`  out  1  1 = make, 0 = break. Valid with `key_strobe` and held until the next strobe.
- `key_extended`  out  1  1 = event was `E0`-prefixed. Held like `key_pressed`.
- `key_code`  out  8  scan code, excluding prefixes. Held like `key_pressed`.
- `frame_err`  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- **Input conditioning**
  - Both inputs pass through 2-FF synchronizers.
  - Synchronized `ps2_clk` feeds a saturating filter counter. The filtered level flips only after `FILTER_LEN` consecutive samples at the opposite level.
  - A bit event is a 1→0 transition of the filtered clock. Data is the synchronized `ps2_data` value in that same cycle.
- **Frame FSM**, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a bit event with data 0 (start bit), go to DATA with bit count 0. A start bit of 1 pulses `frame_err` and stays in IDLE.
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit. Parity is odd, so the data bits XOR the parity bit must equal 1.
  - STOP: the stop bit must be 1 and parity must be good. Then the byte is accepted. Otherwise pulse `frame_err` and discard the byte. Both cases return to IDLE.
  - Timeout: a counter clears on every bit event and counts in every non-IDLE state. When it reaches `TIMEOUT_CYCLES`, pulse `frame_err`, return to IDLE and discard partial data.
- **Prefix layer** (flags `brk_f`, `ext_f`, both 0 at reset):
  - `E0`: set `ext_f`, no strobe.
  - `F0`: set `brk_f`, no strobe.
  - `E1`: discarded, flags unchanged.
  - Any other byte:
    - Drive `key_code` = byte, `key_pressed` = ~`brk_f`, `key_extended` = `ext_f`.
    - Pulse `key_strobe`.
    - Clear both flags.
- Any `frame_err` also clears `brk_f` and `ext_f`.
- The device-side bytes `AA`, `FA`, `EE`, `FE`, `00`, `FF` are emitted as ordinary codes. Filtering them is the consumer's job.

## Timing
- Reset values:
  - `key_strobe` = 0, `frame_err` = 0, `key_pressed` = 0, `key_extended` = 0, `key_code` = 8'h00.
  - FSM in IDLE, flags 0, filtered clock = 1, filter and timeout counters 0.
- All outputs are registered.
- `key_strobe` or `frame_err` rises in the cycle after the cycle in which the stop-bit event is detected. It is high for exactly one cycle.
- Input-to-event latency: 2 sync cycles + `FILTER_LEN` filter cycles + 1 cycle.
- `key_strobe` and `frame_err` are never asserted in the same cycle.
- Back-to-back frames with no idle gap are accepted. IDLE is re-entered the cycle after STOP, so the next start event is recognized.
- A timeout expiring in the same cycle as a bit event: the bit event wins and the counter clears.
- Reset asserted mid-frame: all state returns to reset values immediately. No strobe is produced for the interrupted frame.

## Test plan
- **Make code.** Frame `1C` at a 12 kHz PS/2 clock: bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1.
  - Exactly one `key_strobe`, with `key_code` = 1C, `key_pressed` = 1, `key_extended` = 0.
- **Break and extended sequences.**
  - `F0` then `1C` → one strobe with code 1C, pressed 0, extended 0.
  - `E0 75` → code 75, pressed 1, extended 1.
  - `E0 F0 75` → code 75, pressed 0, extended 1.
  - No strobe on any prefix byte.
- **Parity error recovery.**
  - `E0`, then `1C` with parity 1 → one `frame_err`, no strobe.
  - A following good `1C` → strobe with extended 0, confirming the flag was cleared.
- **Timeout.** Send a start bit plus 4 data bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES`+10 cycles.
  - One `frame_err`.
  - A subsequent full `29` frame yields a strobe with code 29.
- **Glitch rejection.** Inject 0-pulses of `FILTER_LEN`−3 cycles on `ps2_clk` between and inside frames of `6B`.
  - Exactly one strobe with code 6B per frame, and no `frame_err`.
- **Reset mid-frame.** Pulse `res_n` low after 5 bits of a frame, then send `76`.
  - All outputs read reset values during reset.
  - A single strobe with code 76 follows.
